// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the frame FSM state
// encoding, common to the transmit framer and the matching receiver.
package uart_pkg;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] EVEN  = 3'd1;
    localparam logic [2:0] ODD   = 3'd2;
    localparam logic [2:0] MARK  = 3'd3;
    localparam logic [2:0] SPACE = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Parity encodings 5..7 are reserved and behave like NONE.
    function automatic logic parity_enabled(input logic [2:0] ptype);
        return (ptype == EVEN) || (ptype == ODD) ||
               (ptype == MARK) || (ptype == SPACE);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count of every bit. Held at zero while clear is high so the first bit
// of a frame always gets a full period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Free-running bit counter that wraps at the end of each bit period.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity and one
// or two stop bits. A word offered in the last stop cycle follows on with
// no idle gap between frames.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic [2:0]            PARITY_TYPE,
    input  logic                  STOP_BITS,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  PARITY_OUT
);

    localparam int IW = 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    uart_state_t           state, state_next;
    logic [IW-1:0]         bit_idx, bit_idx_next;
    logic                  stop_second, stop_second_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  stop2_reg;
    logic                  tx_reg, tx_next;
    logic                  parity_reg, parity_calc;
    logic                  tick;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_shift;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (CLK),
        .rst_n(RST_N),
        .clear(state == IDLE),
        .tick (tick)
    );

    assign TX_READY   = (state == IDLE) ||
                        ((state == STOP) && tick && (stop_second || !stop2_reg));
    assign accept     = TX_VALID && TX_READY;
    assign TX_OUT     = tx_reg;
    assign BUSY       = (state != IDLE);
    assign PARITY_OUT = parity_reg;

    // Parity of the word currently offered, latched only on accept.
    always_comb begin
        parity_calc = 1'b0;
        case (PARITY_TYPE)
            EVEN:    parity_calc = ^DATA_IN;
            ODD:     parity_calc = ~(^DATA_IN);
            MARK:    parity_calc = 1'b1;
            default: parity_calc = 1'b0;
        endcase
    end

    // Frame sequencing plus the line level to present in the next cycle.
    always_comb begin
        state_next       = state;
        bit_idx_next     = bit_idx;
        stop_second_next = stop_second;
        tx_next          = 1'b1;
        data_shift       = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_IDX) begin
                        state_next       = par_en_reg ? PARITY : STOP;
                        stop_second_next = 1'b0;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next       = STOP;
                    stop_second_next = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop2_reg && !stop_second) begin
                        stop_second_next = 1'b1;
                    end else if (accept) begin
                        state_next   = START;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA: begin
                data_shift = data_reg >> bit_idx_next;
                tx_next    = data_shift[0];
            end
            PARITY:  tx_next = parity_reg;
            default: tx_next = 1'b1;
        endcase
    end

    // State, line register and per-frame configuration captured on accept.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            tx_reg      <= 1'b1;
            parity_reg  <= 1'b0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            stop2_reg   <= 1'b0;
        end else begin
            state       <= state_next;
            bit_idx     <= bit_idx_next;
            stop_second <= stop_second_next;
            tx_reg      <= tx_next;
            if (accept) begin
                data_reg   <= DATA_IN;
                parity_reg <= parity_calc;
                par_en_reg <= parity_enabled(PARITY_TYPE);
                stop2_reg  <= STOP_BITS;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: two instances (8-bit data at 4 clocks/bit,
// 5-bit data at 3 clocks/bit) driven by the same stimulus and compared
// every cycle against a queue of expected line levels built per frame.
module tb_uart_tx_framer;

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [8:0] data_in;
    logic [2:0] parity_type;
    logic       stop_bits;
    logic       tx_valid;
    logic [1:0] tx_ready_w;
    logic [1:0] tx_out_w;
    logic [1:0] busy_w;
    logic [1:0] parity_w;

    int   width_of[2] = '{8, 5};
    int   cpb_of[2]   = '{4, 3};
    exp_t exp_q[2][$];
    logic exp_par[2];
    int   check_count = 0;
    int   error_count = 0;
    int   cycle = 0;

    uart_tx_framer #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4)
    ) dut8 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .DATA_IN    (data_in[7:0]),
        .PARITY_TYPE(parity_type),
        .STOP_BITS  (stop_bits),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready_w[0]),
        .TX_OUT     (tx_out_w[0]),
        .BUSY       (busy_w[0]),
        .PARITY_OUT (parity_w[0])
    );

    uart_tx_framer #(
        .DATA_WIDTH  (5),
        .CLKS_PER_BIT(3)
    ) dut5 (
        .CLK        (clk),
        .RST_N      (rst_n),
        .DATA_IN    (data_in[4:0]),
        .PARITY_TYPE(parity_type),
        .STOP_BITS  (stop_bits),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready_w[1]),
        .TX_OUT     (tx_out_w[1]),
        .BUSY       (busy_w[1]),
        .PARITY_OUT (parity_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
                     tag, cycle, observed, expected);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop bits.
    task automatic pushFrame(input int k, input logic [8:0] d,
                             input logic [2:0] pt, input logic st);
        int   bits[$];
        int   ones;
        logic par;
        exp_t e;
        ones = 0;
        bits.push_back(0);
        for (int i = 0; i < width_of[k]; i++) begin
            bits.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        case (pt)
            3'd1:    par = (ones % 2) == 1;
            3'd2:    par = (ones % 2) == 0;
            3'd3:    par = 1'b1;
            default: par = 1'b0;
        endcase
        if (pt >= 3'd1 && pt <= 3'd4) bits.push_back(int'(par));
        bits.push_back(1);
        if (st) bits.push_back(1);
        exp_par[k] = par;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < cpb_of[k]; c++) begin
                e.tx    = (bits[b] != 0);
                e.busy  = 1'b1;
                e.ready = (b == bits.size() - 1) && (c == cpb_of[k] - 1);
                exp_q[k].push_back(e);
            end
        end
    endtask

    task automatic checkCycle();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (exp_q[k].size() == 0) e = '{tx: 1'b1, busy: 1'b0, ready: 1'b1};
            else                      e = exp_q[k][0];
            checkOutput($sformatf("d%0d.tx", width_of[k]),
                        32'(tx_out_w[k]), 32'(e.tx));
            checkOutput($sformatf("d%0d.busy", width_of[k]),
                        32'(busy_w[k]), 32'(e.busy));
            checkOutput($sformatf("d%0d.ready", width_of[k]),
                        32'(tx_ready_w[k]), 32'(e.ready));
            checkOutput($sformatf("d%0d.parity", width_of[k]),
                        32'(parity_w[k]), 32'(exp_par[k]));
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check outputs.
    task automatic applyStimulus(input logic valid, input logic [8:0] data,
                                 input logic [2:0] ptype, input logic stop,
                                 input logic rst);
        logic acc;
        tx_valid    = valid;
        data_in     = data;
        parity_type = ptype;
        stop_bits   = stop;
        rst_n       = !rst;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_q[k].delete();
                exp_par[k] = 1'b0;
            end else begin
                acc = valid && (exp_q[k].size() <= 1);
                if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
                if (acc) pushFrame(k, data, ptype, stop);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
        checkCycle();
    endtask

    task automatic idleCycles(input int n, input logic [2:0] ptype);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 9'($urandom), ptype, 1'($urandom), 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        tx_valid    = 1'b0;
        data_in     = '0;
        parity_type = '0;
        stop_bits   = 1'b0;
        exp_par     = '{1'b0, 1'b0};

        @(negedge clk);
        applyStimulus(1'b1, 9'h1A5, 3'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'h000, 3'd0, 1'b0, 1'b1);
        idleCycles(10, 3'd0);

        // Even parity, one stop bit.
        applyStimulus(1'b1, 9'h0A5, 3'd1, 1'b0, 1'b0);
        idleCycles(50, 3'd1);

        // Odd parity, two stop bits.
        applyStimulus(1'b1, 9'h0A5, 3'd2, 1'b1, 1'b0);
        idleCycles(55, 3'd2);

        // Back-to-back frames with no parity.
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 9'h000, 3'd0, 1'b0, 1'b0);
        idleCycles(50, 3'd0);

        // Mark then space parity on all-ones data.
        applyStimulus(1'b1, 9'h01F, 3'd3, 1'b0, 1'b0);
        idleCycles(50, 3'd3);
        applyStimulus(1'b1, 9'h01F, 3'd4, 1'b0, 1'b0);
        idleCycles(50, 3'd4);

        // Parity type flipped from even to odd while the frame is in flight.
        applyStimulus(1'b1, 9'h0B7, 3'd1, 1'b0, 1'b0);
        idleCycles(50, 3'd2);

        // Reset during data bit 3 of the 8-bit instance, then a clean frame.
        applyStimulus(1'b1, 9'h0C3, 3'd1, 1'b1, 1'b0);
        idleCycles(17, 3'd1);
        applyStimulus(1'b1, 9'h0FF, 3'd2, 1'b1, 1'b1);
        applyStimulus(1'b1, 9'h055, 3'd2, 1'b0, 1'b0);
        idleCycles(50, 3'd2);

        // Randomized traffic with mid-frame config churn and rare resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 9'($urandom),
                          3'($urandom_range(0, 7)), 1'($urandom),
                          $urandom_range(0, 299) == 0);
        end
        idleCycles(60, 3'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, data bits per frame; legal values 5..9.
REQ-002 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values 2..65535.
REQ-003 Port: CLK, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port: RST_N, input, 1, reset, synchronous and active-low.
REQ-005 Port: DATA_IN, input, DATA_WIDTH, word to transmit, sampled on accept.
REQ-006 Port: PARITY_TYPE, input, 3, parity encoding: 0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 treated as none; sampled on accept.
REQ-007 Port: STOP_BITS, input, 1, stop-bit count: 0 = one stop bit, 1 = two stop bits; sampled on accept.
REQ-008 Port: TX_VALID, input, 1, a word is offered.
REQ-009 Port: TX_READY, output, 1, framer can accept a word this cycle.
REQ-010 Port: TX_OUT, output, 1, serial line, registered, idle high.
REQ-011 Port: BUSY, output, 1, a frame is in progress (any state other than IDLE).
REQ-012 Port: PARITY_OUT, output, 1, parity bit computed for the current frame, registered; held until the next accept.

Function
REQ-013 The accept event SHALL be the cycle in which TX_VALID and TX_READY are both high; DATA_IN, PARITY_TYPE and STOP_BITS SHALL be latched at that edge.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 IDLE SHALL move to START on accept; START SHALL move to DATA; DATA SHALL move to PARITY if parity is enabled, else to STOP; PARITY SHALL move to STOP; STOP SHALL move to IDLE, or to START if an accept occurs.
REQ-016 TX_OUT SHALL go low in the cycle after accept, with zero additional latency.
REQ-017 Every bit SHALL occupy exactly CLKS_PER_BIT cycles, timed by a bit counter that counts 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-018 Data bits SHALL be sent LSB first; a bit index SHALL count 0..DATA_WIDTH-1.
REQ-019 Parity SHALL be computed at accept as follows:
- even: XOR of the data bits;
- odd: inverted XOR of the data bits;
- mark: 1;
- space: 0.
REQ-020 Total frame length SHALL be (1 + DATA_WIDTH + P + S) × CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
REQ-021 TX_READY SHALL be high in IDLE and in the final cycle of the final stop bit, and low otherwise.
REQ-022 An accept in the final stop cycle SHALL start the next frame with no idle gap (back-to-back frames).
REQ-023 TX_VALID deasserted SHALL leave TX_OUT high in IDLE indefinitely.
REQ-024 Changes to DATA_IN, PARITY_TYPE or STOP_BITS mid-frame SHALL have no effect on the frame in flight.
REQ-025 BUSY SHALL be low in IDLE and high in all other states, including the cycle of a back-to-back handoff.

Reset
REQ-026 With RST_N low at a rising edge, the following SHALL hold in the next cycle:
- FSM in IDLE;
- TX_OUT = 1;
- TX_READY = 1;
- BUSY = 0;
- PARITY_OUT = 0;
- bit counter and bit index = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with no completion of the current bit.
REQ-028 TX_VALID during reset SHALL be ignored.

Structure
REQ-029 A shared package uart_pkg SHALL hold the parity-type constants (NONE, EVEN, ODD, MARK, SPACE) and the FSM state encoding, for reuse by the matching receiver.
REQ-030 The bit-period counter SHALL be a sub-module uart_baud_gen that emits a one-cycle tick at count CLKS_PER_BIT-1 and is cleared when the FSM leaves IDLE.

Verification
REQ-031 Even parity: CLKS_PER_BIT=4, DATA_IN=8'hA5, PARITY_TYPE=1, STOP_BITS=0 -> line sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 4 cycles, 44 cycles total, PARITY_OUT=0.
REQ-032 Odd parity with two stop bits: same data, PARITY_TYPE=2, STOP_BITS=1 -> parity bit 1, two stop bits, 48 cycles, BUSY high throughout.
REQ-033 No parity, back-to-back: DATA_IN=8'h00, PARITY_TYPE=0, TX_VALID held high for two words -> second start bit immediately follows the first stop bit, and TX_READY pulses for exactly 1 cycle per frame.
REQ-034 Mark/space at DATA_WIDTH=5: DATA_IN=5'h1F, PARITY_TYPE=3 then 4 -> parity bit 1 then 0, frame 8 bits long.
REQ-035 Reset mid-frame: RST_N low during data bit 3 -> TX_OUT=1 and TX_READY=1 next cycle, and a new accept starts a clean frame.
REQ-036 Config change mid-frame: flip PARITY_TYPE from 1 to 2 during DATA -> transmitted parity matches even.
